// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, parity constants and voting helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte holding register handshake
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick divider, held at zero while disabled
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] clk_div,
  output logic        tick
);
  logic [15:0] count;

  assign tick = en && (count == clk_div);

  // count 0..clk_div, wrapping on the tick; disabled means parked at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with 3-sample majority voting and one-byte holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic [15:0] clk_div,
  input  logic [1:0]  parity_mode,
  input  logic        rx,
  input  logic        err_clr,
  output logic        overrun,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy,
  uart_rx_if.master   data_if
);
  localparam logic [3:0] S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_MID   = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] S_EARLY = S_MID - 4'd1;
  localparam logic [3:0] S_LATE  = S_MID + 4'd1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  rx_state_e              state_q, state_d;
  logic [3:0]             s_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic [1:0]             samp;
  logic                   par_bit;
  logic                   tick;
  logic                   sample_pt, wrap, maj, parity_on, par_bad;
  logic                   stop_ok, stop_bad, accept, load_ok;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign sample_pt = tick && (s_cnt == S_LATE);
  assign wrap      = tick && (s_cnt == S_LAST);
  assign maj       = majority3(samp[0], samp[1], rx_s);
  assign parity_on = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
  assign par_bad   = parity_on && ((^shift ^ par_bit) != (parity_mode == PAR_ODD));
  assign busy      = (state_q != IDLE);
  assign accept    = data_if.rx_valid && data_if.rx_ready;
  assign load_ok   = stop_ok && (!data_if.rx_valid || accept);

  // the counter idles at zero so every frame's bit timing starts at its start edge
  uart_baud_gen u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rx_en && (state_q != IDLE)),
    .clk_div (clk_div),
    .tick    (tick)
  );

  // input synchronizer plus one-cycle edge history; both idle high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  // frame state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and end-of-frame strobes; stop is judged at mid-bit to leave time to resync
  always_comb begin
    state_d  = state_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE:   if (rx_prev && !rx_s) state_d = START;
      START: begin
        if (sample_pt && maj) state_d = IDLE;
        else if (wrap)        state_d = DATA;
      end
      DATA: begin
        if (wrap && (bit_idx == 3'd7)) state_d = parity_on ? PARITY : STOP;
      end
      PARITY: if (wrap) state_d = STOP;
      STOP: begin
        if (sample_pt) begin
          state_d  = IDLE;
          stop_ok  = maj;
          stop_bad = !maj;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d  = IDLE;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
    end
  end

  // oversample position, vote samples and the assembled byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_cnt   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      samp    <= 2'b11;
      par_bit <= 1'b0;
    end else begin
      if (state_q == IDLE) s_cnt <= '0;
      else if (tick)       s_cnt <= s_cnt + 4'd1;
      if (tick && (s_cnt == S_EARLY)) samp[0] <= rx_s;
      if (tick && (s_cnt == S_MID))   samp[1] <= rx_s;
      if (state_q == START && wrap)   bit_idx <= '0;
      if (state_q == DATA && wrap)    bit_idx <= bit_idx + 3'd1;
      if (state_q == DATA && sample_pt)   shift[bit_idx] <= maj;
      if (state_q == PARITY && sample_pt) par_bit <= maj;
    end
  end

  // holding register and sticky flags; a new error outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_if.rx_data  <= '0;
      data_if.rx_valid <= 1'b0;
      overrun          <= 1'b0;
      frame_err        <= 1'b0;
      parity_err       <= 1'b0;
    end else begin
      if (load_ok) begin
        data_if.rx_data  <= shift;
        data_if.rx_valid <= 1'b1;
      end else if (accept) begin
        data_if.rx_valid <= 1'b0;
      end
      overrun    <= (stop_ok && !load_ok) | (overrun & ~err_clr);
      frame_err  <= stop_bad | (frame_err & ~err_clr);
      parity_err <= (stop_ok && par_bad) | (parity_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b1;
  logic        rx = 1'b1;
  logic        err_clr = 1'b0;
  logic [15:0] clk_div = 16'd0;
  logic [1:0]  parity_mode = PAR_NONE;
  logic        overrun, frame_err, parity_err, busy;
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;

  uart_rx_if u_if ();

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_en       (rx_en),
    .clk_div     (clk_div),
    .parity_mode (parity_mode),
    .rx          (rx),
    .err_clr     (err_clr),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy),
    .data_if     (u_if)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  function automatic logic good_par(input logic [7:0] b, input logic [1:0] m);
    return (m == PAR_ODD) ? ~^b : ^b;
  endfunction

  task automatic drive_bits(input logic v, input int n);
    @(posedge clk);
    #1 rx = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic with_par, input logic pbit, input logic stop_v);
    int n;
    n = 16 * (int'(clk_div) + 1);
    drive_bits(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bits(b[i], n);
    if (with_par) drive_bits(pbit, n);
    drive_bits(stop_v, n);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_all();
    @(posedge clk);
    #1 u_if.rx_ready = 1'b1; err_clr = 1'b1;
    @(posedge clk);
    #1 u_if.rx_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (u_if.rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", u_if.rx_data); else passed++;
    total++; if (u_if.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", u_if.rx_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if ({overrun, frame_err, parity_err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {overrun, frame_err, parity_err}); else passed++;
  endtask

  task automatic test_basic();
    int t0;
    int rise;
    clk_div = 16'd0; parity_mode = PAR_NONE; u_if.rx_ready = 1'b0;
    rise = -1;
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        t0 = cyc;
        for (int k = 0; k < 400 && rise < 0; k++) begin
          @(negedge clk);
          if (u_if.rx_valid === 1'b1) rise = cyc - t0;
        end
      end
    join
    settle();
    total++; if (rise < 150 + SYNC || rise > 160 + SYNC)
      $display("FAIL basic_latency: got %0d clks expected about %0d", rise, 153 + SYNC); else passed++;
    total++; if (u_if.rx_data !== 8'h55) $display("FAIL basic_data: got %h expected 55", u_if.rx_data); else passed++;
    total++; if (u_if.rx_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", u_if.rx_valid); else passed++;
    total++; if ({overrun, frame_err, parity_err} !== 3'b000)
      $display("FAIL basic_flags: got %b expected 000", {overrun, frame_err, parity_err}); else passed++;
    @(posedge clk); #1 u_if.rx_ready = 1'b1;
    @(posedge clk); #1 u_if.rx_ready = 1'b0;
    @(negedge clk);
    total++; if (u_if.rx_valid !== 1'b0) $display("FAIL accept_valid: got %b expected 0", u_if.rx_valid); else passed++;
    total++; if (u_if.rx_data !== 8'h55) $display("FAIL accept_data_hold: got %h expected 55", u_if.rx_data); else passed++;
  endtask

  task automatic test_parity();
    clk_div = 16'd3; parity_mode = PAR_EVEN;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    settle();
    total++; if (u_if.rx_data !== 8'hA3) $display("FAIL par_good_data: got %h expected a3", u_if.rx_data); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL par_good_flag: got %b expected 0", parity_err); else passed++;
    clear_all();
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    settle();
    total++; if (u_if.rx_data !== 8'hA3 || u_if.rx_valid !== 1'b1)
      $display("FAIL par_bad_data: got %h/%b expected a3/1", u_if.rx_data, u_if.rx_valid); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL par_bad_flag: got %b expected 1", parity_err); else passed++;
    repeat (50) @(negedge clk);
    total++; if (parity_err !== 1'b1) $display("FAIL par_sticky: got %b expected 1", parity_err); else passed++;
    clear_all();
    @(negedge clk);
    total++; if (parity_err !== 1'b0) $display("FAIL par_clear: got %b expected 0", parity_err); else passed++;
  endtask

  task automatic test_overrun();
    clk_div = 16'd0; parity_mode = PAR_NONE; u_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    settle();
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    settle();
    total++; if (u_if.rx_data !== 8'h11) $display("FAIL ovr_data_kept: got %h expected 11", u_if.rx_data); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else passed++;
    clear_all();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    settle();
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (SYNC + 154) @(posedge clk);
        #1 u_if.rx_ready = 1'b1;
        @(posedge clk);
        #1 u_if.rx_ready = 1'b0;
      end
    join
    settle();
    total++; if (u_if.rx_data !== 8'h22 || u_if.rx_valid !== 1'b1)
      $display("FAIL coincide_data: got %h/%b expected 22/1", u_if.rx_data, u_if.rx_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL coincide_overrun: got %b expected 0", overrun); else passed++;
    clear_all();
  endtask

  task automatic test_frame_err();
    clk_div = 16'd0; parity_mode = PAR_NONE;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    drive_bits(1'b0, 30 * 16);
    @(negedge clk);
    total++; if (u_if.rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b expected 0", u_if.rx_valid); else passed++;
    total++; if (frame_err !== 1'b1) $display("FAIL ferr_flag: got %b expected 1", frame_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ferr_low_line_busy: got %b expected 0", busy); else passed++;
    drive_bits(1'b1, 3 * 16);
    @(negedge clk);
    total++; if (u_if.rx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ferr_recover: got valid %b busy %b expected 0 0", u_if.rx_valid, busy); else passed++;
    clear_all();
  endtask

  task automatic test_glitch_enable();
    clk_div = 16'd0; parity_mode = PAR_NONE;
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 40);
    @(negedge clk);
    total++; if (busy !== 1'b0 || u_if.rx_valid !== 1'b0)
      $display("FAIL glitch_idle: got busy %b valid %b expected 0 0", busy, u_if.rx_valid); else passed++;
    total++; if ({overrun, frame_err, parity_err} !== 3'b000)
      $display("FAIL glitch_flags: got %b expected 000", {overrun, frame_err, parity_err}); else passed++;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (16 * 5 + 8) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL en_busy_before: got %b expected 1", busy); else passed++;
        @(posedge clk);
        #1 rx_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL en_drop_busy: got %b expected 0", busy); else passed++;
      end
    join
    settle();
    rx_en = 1'b1;
    settle();
    total++; if (u_if.rx_valid !== 1'b0) $display("FAIL en_no_delivery: got %b expected 0", u_if.rx_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    clk_div = 16'd0; parity_mode = PAR_NONE; u_if.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    settle();
    total++; if (u_if.rx_valid !== 1'b1) $display("FAIL rstmid_prefill: got %b expected 1", u_if.rx_valid); else passed++;
    b = 8'hA5;
    drive_bits(1'b0, 16);
    for (int i = 0; i < 5; i++) drive_bits(b[i], 16);
    @(posedge clk);
    #1 rx = b[5];
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (u_if.rx_data !== 8'h00 || u_if.rx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_outputs: got %h/%b/%b expected 00/0/0", u_if.rx_data, u_if.rx_valid, busy); else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1; rx = 1'b1;
    drive_bits(1'b1, 32);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    settle();
    total++; if (u_if.rx_data !== 8'h0F || u_if.rx_valid !== 1'b1)
      $display("FAIL rstmid_next_frame: got %h/%b expected 0f/1", u_if.rx_data, u_if.rx_valid); else passed++;
    total++; if ({overrun, frame_err, parity_err} !== 3'b000)
      $display("FAIL rstmid_flags: got %b expected 000", {overrun, frame_err, parity_err}); else passed++;
    clear_all();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [1:0] m;
    logic       bad, with_par, pbit, exp_perr;
    for (int it = 0; it < 8; it++) begin
      b        = 8'($urandom);
      m        = 2'($urandom_range(0, 3));
      bad      = ($urandom_range(0, 2) == 0);
      with_par = (m == PAR_EVEN) || (m == PAR_ODD);
      pbit     = good_par(b, m) ^ bad;
      exp_perr = with_par && bad;
      clk_div     = 16'($urandom_range(0, 3));
      parity_mode = m;
      send_frame(b, with_par, pbit, 1'b1);
      settle();
      total++; if (u_if.rx_data !== b) $display("FAIL rand_data[%0d]: got %h expected %h", it, u_if.rx_data, b); else passed++;
      total++; if (u_if.rx_valid !== 1'b1) $display("FAIL rand_valid[%0d]: got %b expected 1", it, u_if.rx_valid); else passed++;
      total++; if (parity_err !== exp_perr)
        $display("FAIL rand_parity[%0d]: got %b expected %b (mode %0d)", it, parity_err, exp_perr, m); else passed++;
      total++; if ({overrun, frame_err} !== 2'b00)
        $display("FAIL rand_flags[%0d]: got %b expected 00", it, {overrun, frame_err}); else passed++;
      clear_all();
    end
  endtask

  initial begin
    u_if.rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_frame_err();
    test_glitch_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
